// File: rtl/mic1_mem_arbiter.sv
// mic1_mem_arbiter: serialises the mic1 core's write, data read and
// instruction fetch onto a single synchronous 32-bit RAM port. The core is
// held stalled through cpu_run until every requested access has completed.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no access in flight; core runs freely unless a request is up
// WR    | RAM write of MDR to MAR
// DRD   | RAM read issued at MAR
// DCAP  | RAM data word captured into the data result register
// FRD   | RAM read issued at PC word address
// FCAP  | selected instruction byte captured into the fetch register
// REL   | release: core advances on the edge where cpu_run is high
module mic1_mem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              run_en,
  output logic              cpu_run,
  input  logic [31:0]       cpu_mem_addr,
  input  logic [31:0]       cpu_mem_wdata,
  output logic [31:0]       cpu_mem_rdata,
  input  logic [31:0]       cpu_mem_addr_instr,
  output logic [7:0]        cpu_mem_rd_instr,
  input  logic              cpu_mem_read,
  input  logic              cpu_mem_write,
  input  logic              cpu_mem_fetch,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              arb_busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_DRD, S_DCAP, S_FRD, S_FCAP, S_REL
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_wr, r_rd, r_fe;
  logic [31:0] r_rdata;
  logic [7:0]  r_instr;
  logic        w_latch;
  logic        w_clear;
  logic        w_any_req;
  logic [1:0]  w_lane;
  logic [7:0]  w_byte;

  // Upper address bits wrap silently; keep them visibly consumed.
  logic w_unused_bits;
  assign w_unused_bits = ^{cpu_mem_addr[31:ADDR_W], cpu_mem_addr_instr[31:ADDR_W+2]};

  assign w_any_req     = cpu_mem_read | cpu_mem_write | cpu_mem_fetch;
  assign arb_busy      = (r_state != S_IDLE);
  assign cpu_mem_rdata = r_rdata;
  assign cpu_mem_rd_instr = r_instr;

  // Big-endian maps PC lane 0 to the most significant byte, so invert the lane.
  assign w_lane = BIG_ENDIAN ? ~cpu_mem_addr_instr[1:0] : cpu_mem_addr_instr[1:0];

  // Byte lane mux for the fetch capture.
  always_comb begin
    w_byte = ram_rdata[7:0];
    case (w_lane)
      2'd0: w_byte = ram_rdata[7:0];
      2'd1: w_byte = ram_rdata[15:8];
      2'd2: w_byte = ram_rdata[23:16];
      2'd3: w_byte = ram_rdata[31:24];
      default: w_byte = ram_rdata[7:0];
    endcase
  end

  // Next-state and RAM/core handshake outputs.
  always_comb begin
    w_next    = r_state;
    cpu_run   = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    w_latch   = 1'b0;
    w_clear   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_any_req) begin
          cpu_run = run_en;
        end else if (run_en) begin
          w_latch = 1'b1;
          if (cpu_mem_write)     w_next = S_WR;
          else if (cpu_mem_read) w_next = S_DRD;
          else                   w_next = S_FRD;
        end
      end
      S_WR: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = cpu_mem_addr[ADDR_W-1:0];
        ram_wdata = cpu_mem_wdata;
        if (r_rd)      w_next = S_DRD;
        else if (r_fe) w_next = S_FRD;
        else           w_next = S_REL;
      end
      S_DRD: begin
        ram_en   = 1'b1;
        ram_addr = cpu_mem_addr[ADDR_W-1:0];
        w_next   = S_DCAP;
      end
      S_DCAP: begin
        w_next = r_fe ? S_FRD : S_REL;
      end
      S_FRD: begin
        ram_en   = 1'b1;
        ram_addr = cpu_mem_addr_instr[ADDR_W+1:2];
        w_next   = S_FCAP;
      end
      S_FCAP: begin
        w_next = S_REL;
      end
      S_REL: begin
        cpu_run = run_en;
        if (run_en) begin
          w_next  = S_IDLE;
          w_clear = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
    // Reset is synchronous, so the state may still be mid-access until the
    // edge; force the RAM and core quiet for the whole reset window.
    if (!resetn) begin
      cpu_run = 1'b0;
      ram_en  = 1'b0;
      ram_we  = 1'b0;
    end
  end

  // State, request latches and result registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_fe    <= 1'b0;
      r_rdata <= '0;
      r_instr <= '0;
    end else begin
      r_state <= w_next;
      if (w_latch) begin
        r_wr <= cpu_mem_write;
        r_rd <= cpu_mem_read;
        r_fe <= cpu_mem_fetch;
      end else if (w_clear) begin
        r_wr <= 1'b0;
        r_rd <= 1'b0;
        r_fe <= 1'b0;
      end
      if (r_state == S_DCAP) r_rdata <= ram_rdata;
      if (r_state == S_FCAP) r_instr <= w_byte;
    end
  end

endmodule

// File: tb/tb_mic1_mem_arbiter.sv
// Directed bench for mic1_mem_arbiter: two instances (big- and little-endian
// lane select) see identical core stimulus, each with its own RAM model.
module tb_mic1_mem_arbiter;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          resetn;
  logic          run_en;
  logic [31:0]   cpu_mem_addr, cpu_mem_wdata, cpu_mem_addr_instr;
  logic          cpu_mem_read, cpu_mem_write, cpu_mem_fetch;

  logic          cpu_run0, cpu_run1;
  logic [31:0]   rdata0, rdata1;
  logic [7:0]    instr0, instr1;
  logic          ram_en0, ram_en1, ram_we0, ram_we1;
  logic [AW-1:0] ram_addr0, ram_addr1;
  logic [31:0]   ram_wdata0, ram_wdata1;
  logic [31:0]   ram_rdata0, ram_rdata1;
  logic          busy0, busy1;

  logic [31:0]   mem0 [0:(1<<AW)-1];
  logic [31:0]   mem1 [0:(1<<AW)-1];

  int            n_chk = 0;
  int            n_err = 0;
  logic [31:0]   q_addr [$];
  logic          q_we   [$];
  int            stalls;

  always #5 clk = ~clk;

  mic1_mem_arbiter #(.ADDR_W(AW), .BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .resetn(resetn), .run_en(run_en), .cpu_run(cpu_run0),
    .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata),
    .cpu_mem_rdata(rdata0), .cpu_mem_addr_instr(cpu_mem_addr_instr),
    .cpu_mem_rd_instr(instr0), .cpu_mem_read(cpu_mem_read),
    .cpu_mem_write(cpu_mem_write), .cpu_mem_fetch(cpu_mem_fetch),
    .ram_en(ram_en0), .ram_we(ram_we0), .ram_addr(ram_addr0),
    .ram_wdata(ram_wdata0), .ram_rdata(ram_rdata0), .arb_busy(busy0)
  );

  mic1_mem_arbiter #(.ADDR_W(AW), .BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .resetn(resetn), .run_en(run_en), .cpu_run(cpu_run1),
    .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata),
    .cpu_mem_rdata(rdata1), .cpu_mem_addr_instr(cpu_mem_addr_instr),
    .cpu_mem_rd_instr(instr1), .cpu_mem_read(cpu_mem_read),
    .cpu_mem_write(cpu_mem_write), .cpu_mem_fetch(cpu_mem_fetch),
    .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1),
    .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1), .arb_busy(busy1)
  );

  // Synchronous read-first RAMs, preloaded before the first clock edge.
  always @(posedge clk) begin
    if (ram_en0) begin
      ram_rdata0 <= mem0[ram_addr0];
      if (ram_we0) mem0[ram_addr0] = ram_wdata0;
    end
    if (ram_en1) begin
      ram_rdata1 <= mem1[ram_addr1];
      if (ram_we1) mem1[ram_addr1] = ram_wdata1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Raise one microinstruction's requests (called just after a posedge while
  // idle), count stall cycles until cpu_run, log RAM accesses, then drop the
  // requests right after the release edge.
  task automatic access(input logic w, input logic r, input logic f,
                        input logic [31:0] mar, input logic [31:0] mdr,
                        input logic [31:0] pc, output int st);
    bit done = 0;
    cpu_mem_write      = w;
    cpu_mem_read       = r;
    cpu_mem_fetch      = f;
    cpu_mem_addr       = mar;
    cpu_mem_wdata      = mdr;
    cpu_mem_addr_instr = pc;
    st = 0;
    q_addr.delete();
    q_we.delete();
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      if (ram_en0) begin
        q_addr.push_back(32'(ram_addr0));
        q_we.push_back(ram_we0);
      end
      if (cpu_run0) done = 1;
      else st++;
    end
    if (!done) chk("release_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    cpu_mem_write = 1'b0;
    cpu_mem_read  = 1'b0;
    cpu_mem_fetch = 1'b0;
  endtask

  task automatic wait_drd();
    bit seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (ram_en0 && !ram_we0) seen = 1;
    end
    if (!seen) chk("drd_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) begin
      mem0[i] = 32'h0;
      mem1[i] = 32'h0;
    end
    mem0[0] = 32'hCAFEF00D; mem1[0] = 32'hCAFEF00D;
    mem0[2] = 32'h000000A5; mem1[2] = 32'h000000A5;
    mem0[3] = 32'h11223344; mem1[3] = 32'h11223344;

    resetn = 1'b0; run_en = 1'b1;
    cpu_mem_read = 1'b0; cpu_mem_write = 1'b0; cpu_mem_fetch = 1'b0;
    cpu_mem_addr = '0; cpu_mem_wdata = '0; cpu_mem_addr_instr = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_run", 32'(cpu_run0), 32'd0);
    chk("rst_ram_en",  32'(ram_en0),  32'd0);
    chk("rst_busy",    32'(busy0),    32'd0);
    chk("rst_rdata",   rdata0,        32'd0);
    chk("rst_instr",   32'(instr0),   32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("idle_run", 32'(cpu_run0), 32'd1);
    @(posedge clk); #1;

    // Write then read back.
    access(1, 0, 0, 32'd5, 32'hDEADBEEF, 32'd0, stalls);
    chk("wr_stall", stalls, 32'd2);
    chk("wr_nacc",  q_addr.size(), 32'd1);
    chk("wr_addr",  q_addr[0], 32'd5);
    chk("wr_we",    32'(q_we[0]), 32'd1);
    chk("wr_mem",   mem0[5], 32'hDEADBEEF);
    access(0, 1, 0, 32'd5, 32'd0, 32'd0, stalls);
    chk("rd_stall", stalls, 32'd3);
    chk("rd_we",    32'(q_we[0]), 32'd0);
    chk("rd_data",  rdata0, 32'hDEADBEEF);

    // Fetch byte lanes.
    access(0, 0, 1, 32'd0, 32'd0, 32'h0D, stalls);
    chk("fe_stall",  stalls, 32'd3);
    chk("fe_addr",   q_addr[0], 32'd3);
    chk("fe_be_0d",  32'(instr0), 32'h22);
    chk("fe_le_0d",  32'(instr1), 32'h33);
    access(0, 0, 1, 32'd0, 32'd0, 32'h0F, stalls);
    chk("fe_be_0f",  32'(instr0), 32'h44);
    chk("fe_le_0f",  32'(instr1), 32'h11);

    // Read + fetch in one microinstruction.
    access(0, 1, 1, 32'd2, 32'd0, 32'd0, stalls);
    chk("rf_stall", stalls, 32'd5);
    chk("rf_nacc",  q_addr.size(), 32'd2);
    chk("rf_addr0", q_addr[0], 32'd2);
    chk("rf_addr1", q_addr[1], 32'd0);
    chk("rf_rdata", rdata0, 32'hA5);
    chk("rf_instr", 32'(instr0), 32'hCA);

    // Write + read same address: read sees the new data.
    access(1, 1, 0, 32'd7, 32'h55, 32'd0, stalls);
    chk("wrd_stall", stalls, 32'd4);
    chk("wrd_we0",   32'(q_we[0]), 32'd1);
    chk("wrd_we1",   32'(q_we[1]), 32'd0);
    chk("wrd_data",  rdata0, 32'h55);

    // Write + read + fetch.
    access(1, 1, 1, 32'd8, 32'h99, 32'h0C, stalls);
    chk("wrf_stall", stalls, 32'd6);
    chk("wrf_data",  rdata0, 32'h99);
    chk("wrf_instr", 32'(instr0), 32'h11);

    // Address wrap above ADDR_W.
    access(1, 0, 0, 32'h401, 32'h77, 32'd0, stalls);
    chk("wrap_addr", q_addr[0], 32'd1);
    chk("wrap_mem",  mem0[1], 32'h77);

    // Request held off by run_en=0 in IDLE.
    run_en = 1'b0;
    cpu_mem_read = 1'b1;
    cpu_mem_addr = 32'd2;
    repeat (2) @(negedge clk);
    chk("hold_busy",   32'(busy0),    32'd0);
    chk("hold_ram_en", 32'(ram_en0),  32'd0);
    chk("hold_run",    32'(cpu_run0), 32'd0);
    @(posedge clk); #1;
    run_en = 1'b1;

    // run_en dropped during DCAP parks in REL.
    wait_drd();
    @(negedge clk);
    run_en = 1'b0;
    @(negedge clk);
    chk("park_busy",  32'(busy0),    32'd1);
    chk("park_run",   32'(cpu_run0), 32'd0);
    chk("park_rdata", rdata0,        32'hA5);
    repeat (3) @(negedge clk);
    chk("park_hold",  32'(busy0 & ~cpu_run0), 32'd1);
    run_en = 1'b1;
    #1;
    chk("unpark_run", 32'(cpu_run0), 32'd1);
    @(posedge clk); #1;
    cpu_mem_read = 1'b0;
    run_en = 1'b0;
    @(negedge clk);
    chk("unpark_idle", 32'(busy0),    32'd0);
    chk("unpark_run1", 32'(cpu_run0), 32'd0);
    @(posedge clk); #1;
    run_en = 1'b1;

    // Reset during DRD.
    cpu_mem_read = 1'b1;
    cpu_mem_addr = 32'd5;
    wait_drd();
    resetn = 1'b0;
    #1;
    chk("rstd_ram_en", 32'(ram_en0),  32'd0);
    chk("rstd_run",    32'(cpu_run0), 32'd0);
    @(posedge clk); #1;
    cpu_mem_read = 1'b0;
    @(negedge clk);
    chk("rstd_busy",   32'(busy0),    32'd0);
    chk("rstd_ram_en2",32'(ram_en0),  32'd0);
    chk("rstd_rdata",  rdata0,        32'd0);
    chk("rstd_run2",   32'(cpu_run0), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_run", 32'(cpu_run0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mic1_mem_arbiter.md
Name: mic1_mem_arbiter

Overview:
Single-port memory controller between the mic1 core and one synchronous 32-bit word RAM.
- Serialises the core's data write, data read and instruction fetch onto the one RAM port.
- Stalls the core through its run input until every access requested by the current microinstruction has completed.
- Holds the read results on the core's mem_rdata and mem_rd_instr inputs so the core captures them on the release edge.

Parameters:
ADDR_W, 10, RAM word-address width; upper core address bits are ignored.
BIG_ENDIAN, 1, instruction byte lane select: 1 = PC[1:0]==0 selects bits [31:24]; 0 = selects bits [7:0].

Ports:
clk  input  1  clock
resetn  input  1  synchronous, active-low reset
run_en  input  1  host enable for the core
cpu_run  output  1  drives the core's run input
cpu_mem_addr  input  32  core MAR (word address)
cpu_mem_wdata  input  32  core MDR
cpu_mem_rdata  output  32  data read result to the core
cpu_mem_addr_instr  input  32  core PC (byte address)
cpu_mem_rd_instr  output  8  fetched byte to the core
cpu_mem_read  input  1  core read request
cpu_mem_write  input  1  core write request
cpu_mem_fetch  input  1  core fetch request
ram_en  output  1  RAM access enable
ram_we  output  1  RAM write enable
ram_addr  output  ADDR_W  RAM word address
ram_wdata  output  32  RAM write data
ram_rdata  input  32  RAM read data, valid on the cycle after ram_en with ram_we=0
arb_busy  output  1  high while state != IDLE

Behaviour:
- Reset (resetn=0 at posedge):
  - state goes to IDLE.
  - rdata_q and instr_q are cleared to 0.
  - Pending-request latches are cleared.
  - Any in-flight access is abandoned.
  - While in reset: ram_en=0, ram_we=0, cpu_run=0.
- Request signals come from core registers and are stable for a whole cycle. cpu_run is combinational:
  - IDLE with no request: cpu_run = run_en.
  - IDLE with any request: cpu_run = 0.
  - REL: cpu_run = run_en.
  - All other states: cpu_run = 0.
- States: IDLE, WR, DRD, DCAP, FRD, FCAP, REL.
- In IDLE, when any request is high and run_en=1:
  - Latch the write, read and fetch flags.
  - Go to the first pending state in fixed order: WR, then DRD, then FRD.
- WR (1 cycle):
  - ram_en=1, ram_we=1, ram_addr=cpu_mem_addr[ADDR_W-1:0], ram_wdata=cpu_mem_wdata.
  - Next state: DRD if read is latched, else FRD if fetch is latched, else REL.
- DRD:
  - ram_en=1, ram_we=0, ram_addr=cpu_mem_addr[ADDR_W-1:0].
  - Next state: DCAP.
- DCAP:
  - rdata_q <= ram_rdata.
  - Next state: FRD if fetch is latched, else REL.
- FRD:
  - ram_en=1, ram_we=0, ram_addr=cpu_mem_addr_instr[ADDR_W+1:2]; lane is PC[1:0].
  - Next state: FCAP.
- FCAP:
  - instr_q <= selected byte of ram_rdata, with the lane chosen per BIG_ENDIAN.
  - Next state: REL.
- REL:
  - The core advances on the posedge where cpu_run=1.
  - Then go to IDLE and clear the latched flags.
  - If run_en=0, remain in REL until run_en=1.
- Outputs:
  - cpu_mem_rdata = rdata_q and cpu_mem_rd_instr = instr_q.
  - Both hold until overwritten.
  - ram_wdata = 0 and ram_addr = 0 when not in WR, DRD or FRD.
- Stall length (cycles with cpu_run=0, counted from the first request cycle):
  - write only: 2
  - read only: 3
  - fetch only: 3
  - read + fetch: 5
  - write + read + fetch: 6
- Write and read in the same microinstruction: the write is performed first, so the read returns the newly written data.
- run_en=0 while in IDLE with a request pending: stay in IDLE; no access starts.
- run_en falling mid-sequence: the sequence completes and the block parks in REL.
- Address bits above ADDR_W are ignored (wrap-around); no error is flagged.
- Core request lines may change only after a release edge. The arbiter does not sample them outside IDLE, except for addresses and data, which are held by the stalled core.

Test Plan:
- Reset mid-DRD (assert resetn=0 in DRD) -> next cycle state=IDLE, arb_busy=0, ram_en=0, cpu_mem_rdata=0, cpu_run=0 while resetn=0.
- Write MAR=5, MDR=0xDEADBEEF -> ram_we=1 with ram_addr=5 for 1 cycle, cpu_run low 2 cycles; a later read of MAR=5 -> cpu_mem_rdata=0xDEADBEEF after 3 stall cycles.
- Fetch with RAM word 3 = 0x11223344 and PC=0x0D, BIG_ENDIAN=1 -> cpu_mem_rd_instr=0x22; PC=0x0F -> 0x44; with BIG_ENDIAN=0, PC=0x0D -> 0x33.
- Read MAR=2 (RAM word 2 = 0xA5) plus fetch PC=0 in the same cycle -> DRD then FRD order on ram_addr (2, then 0), exactly 5 stall cycles, both results valid at the release edge.
- Write and read both to MAR=7 with MDR=0x55 -> write precedes read, cpu_mem_rdata=0x55.
- Drop run_en during DCAP -> state parks in REL with cpu_run=0; raise run_en -> cpu_run=1 for exactly one cycle, then IDLE. MAR=0x401 with ADDR_W=10 -> ram_addr=1.
